// File: rtl/gray2rgb_colormap.sv
// rtl/gray2rgb_colormap.sv - grayscale to RGB888 colormap, two-stage pipeline with backpressure
module gray2rgb_colormap #(
    parameter int Pixel_Width = 24
) (
    input  logic                   I_clk,
    input  logic                   I_reset_n,
    input  logic                   I_pixel_data_valid,
    output logic                   O_pixel_data_ready,
    input  logic [7:0]             I_pixel_data_Gray,
    input  logic                   I_sof,
    input  logic                   I_eol,
    input  logic [1:0]             I_mode,
    input  logic [7:0]             I_threshold,
    output logic                   O_pixel_data_valid,
    input  logic                   I_pixel_data_ready,
    output logic [Pixel_Width-1:0] O_pixel_data_RGB,
    output logic                   O_sof,
    output logic                   O_eol
);

    logic       en;
    logic       accept;
    logic       sof_accept;
    logic [1:0] mode_q;
    logic [7:0] thr_q;
    logic [1:0] mode_in;
    logic [7:0] thr_in;

    logic       s1_valid;
    logic [7:0] s1_gray;
    logic       s1_sof;
    logic       s1_eol;
    logic [1:0] s1_mode;
    logic [7:0] s1_thr;

    logic [7:0]             ramp;
    logic [Pixel_Width-1:0] rgb_next;

    // The whole pipe advances together; an empty output slot never blocks upstream.
    assign en                 = ~O_pixel_data_valid | I_pixel_data_ready;
    assign O_pixel_data_ready = en;
    assign accept             = I_pixel_data_valid & en;
    assign sof_accept         = accept & I_sof;

    // The SOF beat itself must already see the new settings, so bypass the latch for it.
    assign mode_in = sof_accept ? I_mode      : mode_q;
    assign thr_in  = sof_accept ? I_threshold : thr_q;

    // Frame-synchronous settings: only an accepted SOF beat updates mode and threshold.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            mode_q <= 2'd0;
            thr_q  <= 8'd0;
        end else if (sof_accept) begin
            mode_q <= I_mode;
            thr_q  <= I_threshold;
        end
    end

    // Stage 1: capture the sample together with the settings it will be mapped with.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            s1_valid <= 1'b0;
            s1_gray  <= 8'd0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_mode  <= 2'd0;
            s1_thr   <= 8'd0;
        end else if (en) begin
            s1_valid <= I_pixel_data_valid;
            s1_gray  <= I_pixel_data_Gray;
            s1_sof   <= I_sof & I_pixel_data_valid;
            s1_eol   <= I_eol & I_pixel_data_valid;
            s1_mode  <= mode_in;
            s1_thr   <= thr_in;
        end
    end

    // Colour mapping; the jet ramp is the low six bits scaled to 0..252 within each quarter.
    always_comb begin
        ramp     = {s1_gray[5:0], 2'b00};
        rgb_next = {s1_gray, s1_gray, s1_gray};
        case (s1_mode)
            2'd1: begin
                case (s1_gray[7:6])
                    2'd0:    rgb_next = {8'h00, ramp, 8'hFF};
                    2'd1:    rgb_next = {8'h00, 8'hFF, 8'hFF - ramp};
                    2'd2:    rgb_next = {ramp, 8'hFF, 8'h00};
                    default: rgb_next = {8'hFF, 8'hFF - ramp, 8'h00};
                endcase
            end
            2'd2: begin
                if (s1_gray >= s1_thr) begin
                    rgb_next = 24'hFF0000;
                end
            end
            default: rgb_next = {s1_gray, s1_gray, s1_gray};
        endcase
    end

    // Stage 2: registered output beat, held while downstream stalls.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            O_pixel_data_valid <= 1'b0;
            O_pixel_data_RGB   <= '0;
            O_sof              <= 1'b0;
            O_eol              <= 1'b0;
        end else if (en) begin
            O_pixel_data_valid <= s1_valid;
            O_pixel_data_RGB   <= rgb_next;
            O_sof              <= s1_sof;
            O_eol              <= s1_eol;
        end
    end

endmodule

// File: tb/tb_gray2rgb_colormap.sv
// tb/tb_gray2rgb_colormap.sv - scoreboard bench for gray2rgb_colormap
module tb_gray2rgb_colormap;

    logic        I_clk = 1'b0;
    logic        I_reset_n;
    logic        I_pixel_data_valid;
    logic        O_pixel_data_ready;
    logic [7:0]  I_pixel_data_Gray;
    logic        I_sof;
    logic        I_eol;
    logic [1:0]  I_mode;
    logic [7:0]  I_threshold;
    logic        O_pixel_data_valid;
    logic        I_pixel_data_ready;
    logic [23:0] O_pixel_data_RGB;
    logic        O_sof;
    logic        O_eol;

    gray2rgb_colormap #(.Pixel_Width(24)) dut (
        .I_clk              (I_clk),
        .I_reset_n          (I_reset_n),
        .I_pixel_data_valid (I_pixel_data_valid),
        .O_pixel_data_ready (O_pixel_data_ready),
        .I_pixel_data_Gray  (I_pixel_data_Gray),
        .I_sof              (I_sof),
        .I_eol              (I_eol),
        .I_mode             (I_mode),
        .I_threshold        (I_threshold),
        .O_pixel_data_valid (O_pixel_data_valid),
        .I_pixel_data_ready (I_pixel_data_ready),
        .O_pixel_data_RGB   (O_pixel_data_RGB),
        .O_sof              (O_sof),
        .O_eol              (O_eol)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         lat_chk = 1'b1;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_thr = 8'd0;

    always @(posedge I_clk) cyc <= cyc + 1;

    // Reference colormap written from the mapping table.
    function automatic logic [23:0] ref_rgb(input logic [7:0] g, input logic [1:0] m, input logic [7:0] t);
        int   gi;
        logic [7:0] f;
        gi = int'(g);
        f  = 8'((gi % 64) * 4);
        if (m == 2'd1) begin
            if (gi < 64)       return {8'h00, f, 8'hFF};
            else if (gi < 128) return {8'h00, 8'hFF, 8'(255 - int'(f))};
            else if (gi < 192) return {f, 8'hFF, 8'h00};
            else               return {8'hFF, 8'(255 - int'(f)), 8'h00};
        end
        if (m == 2'd2 && g >= t) return 24'hFF0000;
        return {g, g, g};
    endfunction

    // Output monitor: pop and compare on every beat that will transfer at the next edge.
    always @(negedge I_clk) begin
        if (mon_en && O_pixel_data_valid && I_pixel_data_ready) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_output got %h required none", O_pixel_data_RGB);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                assert ({O_pixel_data_RGB, O_sof, O_eol} === {e.rgb, e.sof, e.eol}) else begin
                    n_err++;
                    $error("FAIL beat got rgb=%h sof=%b eol=%b required rgb=%h sof=%b eol=%b",
                           O_pixel_data_RGB, O_sof, O_eol, e.rgb, e.sof, e.eol);
                end
                if (lat_chk) begin
                    n_cmp++;
                    assert ((cyc - e.cyc) === 2) else begin
                        n_err++;
                        $error("FAIL latency got %0d required 2", cyc - e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge I_clk);
        #1;
    endtask

    // Present one beat until accepted; the model latches settings on an accepted SOF.
    task automatic send(input logic [7:0] g, input logic s, input logic e);
        bit   acc;
        int   tries;
        exp_t x;
        I_pixel_data_Gray  = g;
        I_sof              = s;
        I_eol              = e;
        I_pixel_data_valid = 1'b1;
        acc   = 1'b0;
        tries = 0;
        x.cyc = 0;
        while (!acc && tries < 50) begin
            @(negedge I_clk);
            acc   = O_pixel_data_ready;
            x.cyc = cyc;
            @(posedge I_clk);
            #1;
            tries++;
        end
        I_pixel_data_valid = 1'b0;
        I_sof              = 1'b0;
        I_eol              = 1'b0;
        n_cmp++;
        assert (acc) else begin
            n_err++;
            $error("FAIL accept_timeout got not_accepted required accepted gray=%h", g);
        end
        if (acc) begin
            if (s) begin
                m_mode = I_mode;
                m_thr  = I_threshold;
            end
            x.rgb = ref_rgb(g, m_mode, m_thr);
            x.sof = s;
            x.eol = e;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(negedge I_clk);
            t++;
        end
        tick(1);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        logic [23:0] held_rgb;
        logic        held_sof;
        logic        held_eol;

        I_reset_n          = 1'b0;
        I_pixel_data_valid = 1'b0;
        I_pixel_data_Gray  = 8'h00;
        I_sof              = 1'b0;
        I_eol              = 1'b0;
        I_mode             = 2'd0;
        I_threshold        = 8'h00;
        I_pixel_data_ready = 1'b1;

        // Reset state
        tick(3);
        @(negedge I_clk);
        n_cmp++;
        assert ({O_pixel_data_valid, O_pixel_data_RGB, O_sof, O_eol, O_pixel_data_ready} === {1'b0, 24'h0, 1'b0, 1'b0, 1'b1}) else begin
            n_err++;
            $error("FAIL reset_state got v=%b rgb=%h sof=%b eol=%b rdy=%b required 0 000000 0 0 1",
                   O_pixel_data_valid, O_pixel_data_RGB, O_sof, O_eol, O_pixel_data_ready);
        end
        @(posedge I_clk);
        #1;
        I_reset_n = 1'b1;
        mon_en    = 1'b1;

        // Gray mode
        send(8'h00, 1'b1, 1'b0);
        send(8'h80, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        drain();

        // Jet mode latched on SOF
        I_mode = 2'd1;
        send(8'd0,   1'b1, 1'b0);
        send(8'd63,  1'b0, 1'b0);
        send(8'd64,  1'b0, 1'b0);
        send(8'd128, 1'b0, 1'b0);
        send(8'd192, 1'b0, 1'b0);
        send(8'd255, 1'b0, 1'b1);
        drain();

        // Threshold mode; mid-frame threshold/mode changes ignored until next SOF
        I_mode      = 2'd2;
        I_threshold = 8'h80;
        send(8'h7F, 1'b1, 1'b0);
        send(8'h80, 1'b0, 1'b0);
        I_threshold = 8'h10;
        I_mode      = 2'd0;
        send(8'h20, 1'b0, 1'b1);
        I_mode = 2'd2;
        send(8'h20, 1'b1, 1'b0);
        send(8'h0F, 1'b0, 1'b1);
        drain();

        // Backpressure: 10 pixels with a 5-cycle downstream stall
        lat_chk = 1'b0;
        I_mode  = 2'd1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(8'(i * 25 + 3), i == 0, (i == 4) || (i == 9));
                end
            end
            begin
                tick(5);
                I_pixel_data_ready = 1'b0;
                @(negedge I_clk);
                held_rgb = O_pixel_data_RGB;
                held_sof = O_sof;
                held_eol = O_eol;
                n_cmp++;
                assert (O_pixel_data_valid === 1'b1) else begin
                    n_err++;
                    $error("FAIL stall_valid got %b required 1", O_pixel_data_valid);
                end
                for (int k = 0; k < 4; k++) begin
                    @(negedge I_clk);
                    n_cmp++;
                    assert ({O_pixel_data_valid, O_pixel_data_RGB, O_sof, O_eol, O_pixel_data_ready} ===
                            {1'b1, held_rgb, held_sof, held_eol, 1'b0}) else begin
                        n_err++;
                        $error("FAIL stall_hold got v=%b rgb=%h sof=%b eol=%b rdy=%b required 1 %h %b %b 0",
                               O_pixel_data_valid, O_pixel_data_RGB, O_sof, O_eol, O_pixel_data_ready,
                               held_rgb, held_sof, held_eol);
                    end
                end
                @(posedge I_clk);
                #1;
                I_pixel_data_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Mode switch mid-frame takes effect only at the next SOF
        I_mode = 2'd0;
        send(8'h10, 1'b1, 1'b0);
        send(8'h90, 1'b0, 1'b1);
        I_mode = 2'd1;
        send(8'h90, 1'b0, 1'b0);
        send(8'h90, 1'b1, 1'b0);
        send(8'h30, 1'b0, 1'b1);
        drain();

        // Reset with two beats in flight
        I_mode = 2'd1;
        send(8'hC0, 1'b1, 1'b0);
        send(8'h40, 1'b0, 1'b0);
        mon_en    = 1'b0;
        I_reset_n = 1'b0;
        sb.delete();
        m_mode = 2'd0;
        m_thr  = 8'h00;
        @(negedge I_clk);
        @(negedge I_clk);
        n_cmp++;
        assert ({O_pixel_data_valid, O_pixel_data_RGB, O_sof, O_eol, O_pixel_data_ready} === {1'b0, 24'h0, 1'b0, 1'b0, 1'b1}) else begin
            n_err++;
            $error("FAIL reset_flush got v=%b rgb=%h sof=%b eol=%b rdy=%b required 0 000000 0 0 1",
                   O_pixel_data_valid, O_pixel_data_RGB, O_sof, O_eol, O_pixel_data_ready);
        end
        @(posedge I_clk);
        #1;
        I_reset_n = 1'b1;
        mon_en    = 1'b1;
        send(8'h40, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gray2rgb_colormap.md
# gray2rgb_colormap

Converts the 8-bit grayscale/flow-magnitude pixel stream back into RGB888 for the display path. Three selectable mappings: plain gray replication, a 4-segment jet pseudo-colormap, and a threshold highlight. Sits after the flow-estimation/gray processing stages and before the RGB display/HDMI output. Two-stage pipeline with valid/ready backpressure and frame-synchronous mode switching.

## Interface
- Pixel_Width, 24, output RGB width; fixed 24, RGB888 packing [23:16]=R, [15:8]=G, [7:0]=B
- I_clk  in  1  single clock; all logic on rising edge
- I_reset_n  in  1  synchronous, active-low reset
- I_pixel_data_valid  in  1  input beat valid
- O_pixel_data_ready  out  1  input beat accepted when valid & ready
- I_pixel_data_Gray  in  8  gray/magnitude sample
- I_sof  in  1  sideband: first pixel of frame
- I_eol  in  1  sideband: last pixel of line
- I_mode  in  2  0=gray, 1=jet, 2=threshold, 3=reserved (treated as 0)
- I_threshold  in  8  threshold for mode 2
- O_pixel_data_valid  out  1  output beat valid
- I_pixel_data_ready  in  1  downstream ready
- O_pixel_data_RGB  out  Pixel_Width  RGB888 result
- O_sof  out  1  I_sof aligned to output beat
- O_eol  out  1  I_eol aligned to output beat

## Operation
- Global stall enable: en = ~O_pixel_data_valid | I_pixel_data_ready; O_pixel_data_ready = en (combinational).
- Stage 1 (on en): s1_valid <= in_valid; capture gray, sof, eol; seg = gray[7:6]; f = {gray[5:0],2'b00} (0..252).
- Mode/threshold latch: on accepted beat with I_sof=1, mode_q <= I_mode, thr_q <= I_threshold; that beat and all following beats until next accepted SOF use the new values. Changes to I_mode between SOFs are ignored.
- Stage 2 (on en): O_pixel_data_valid <= s1_valid; O_sof/O_eol forwarded; RGB computed:
  - mode 0/3: R=G=B=gray.
  - mode 1 (jet): seg0 -> (0, f, 255); seg1 -> (0, 255, 255-f); seg2 -> (f, 255, 0); seg3 -> (255, 255-f, 0). All 8-bit, no overflow possible.
  - mode 2: gray >= thr_q -> (255, 0, 0); else R=G=B=gray.
- Mode applied at stage 2 is the mode captured with the beat in stage 1 (mode travels with data), so no tearing on the SOF beat.
- Invalid input beats (valid=0) still advance the pipeline when en=1, creating bubbles; they never set O_pixel_data_valid.

## Timing
- Latency: 2 cycles accepted-input to O_pixel_data_valid with no stall; throughput 1 pixel/cycle.
- Stall: while O_pixel_data_valid=1 and I_pixel_data_ready=0, all registers hold; O_pixel_data_RGB/O_sof/O_eol stable; O_pixel_data_ready=0.
- Output not valid: en=1 regardless of I_pixel_data_ready (bubbles collapse).
- Reset (I_reset_n=0 at clock edge): O_pixel_data_valid=0, s1_valid=0, O_pixel_data_RGB=0, O_sof=0, O_eol=0, mode_q=0, thr_q=0. O_pixel_data_ready=1 during and after reset (output invalid). Reset mid-frame discards in-flight beats; no partial output emitted; gray mode until next SOF.
- Simultaneous SOF beat and stall: mode latch only on actual acceptance (valid & ready).

## Test plan
- Mode 0, reset release, stream 0x00,0x80,0xFF with ready=1 -> RGB 0x000000,0x808080,0xFFFFFF exactly 2 cycles after each input.
- Mode 1 on SOF beat, gray 0,63,64,128,192,255 -> 0x0000FF,0x00FCFF,0x00FFFF,0x00FF00,0xFFFF00,0xFF0300.
- Mode 2, thr=0x80 latched at SOF, gray 0x7F,0x80 -> 0x7F7F7F,0xFF0000; change I_threshold to 0x10 mid-frame -> no effect until next SOF.
- Backpressure: hold I_pixel_data_ready=0 for 5 cycles mid-stream of 10 pixels -> output held stable, O_pixel_data_ready=0, no pixel lost/duplicated, sequence and O_sof/O_eol order intact.
- Switch I_mode 0->1 mid-frame, then SOF beat -> pixels before SOF gray-replicated, SOF pixel and after jet-mapped.
- Assert I_reset_n=0 with 2 beats in flight -> next cycle O_pixel_data_valid=0, RGB=0; post-reset pixel uses mode 0.
